// File: rtl/spi_reg_bank.sv
// ---------------------------------------------------------------------------
// spi_reg_bank
//   Register bank behind an SPI slave front-end. Command bytes select a read
//   or write transaction and a target address; data words are then written to
//   control registers or read back from control/status registers through a
//   registered txd_data word that is stable before the next data transaction.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   dcmd       command byte {wr, ainc, addr[5:0]}, valid with cmd_done
//   cmd_done   1-cycle pulse: command byte complete
//   rxd_data   received data word, valid with data_done
//   data_done  1-cycle pulse: data transaction complete
//   txd_data   word to send on the next data transaction
//   stat_flat  status inputs, reg NUM_CTRL+i = stat_flat[i*DW +: DW]
//   ctrl_flat  control registers, reg i = ctrl_flat[i*DW +: DW]
//   wr_strobe  1-cycle pulse after a control register write
//   wr_addr    address of the last control write
//   err        sticky protocol/address error flag
//   err_clr    clears err unless a new error occurs in the same cycle
// ---------------------------------------------------------------------------
module spi_reg_bank #(
   parameter int DATA_WIDTH = 16,
   parameter int CMD_WIDTH  = 8,
   parameter int NUM_CTRL   = 8,
   parameter int NUM_STAT   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [CMD_WIDTH-1:0]           dcmd,
   input  logic                           cmd_done,
   input  logic [DATA_WIDTH-1:0]          rxd_data,
   input  logic                           data_done,
   output logic [DATA_WIDTH-1:0]          txd_data,
   input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_flat,
   output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_flat,
   output logic                           wr_strobe,
   output logic [5:0]                     wr_addr,
   output logic                           err,
   input  logic                           err_clr
);

   localparam logic [5:0] LAST   = 6'(NUM_CTRL + NUM_STAT - 1);
   localparam logic [5:0] CTRL_N = 6'(NUM_CTRL);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_ARMED = 2'd1,
      RD_ARMED = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nx;
   logic [5:0]            r_addr;
   logic [5:0]            w_addr_nx;
   logic                  r_ainc;
   logic                  w_ainc_nx;
   logic                  w_wr_en;
   logic                  w_err_set;
   logic [DATA_WIDTH-1:0] r_ctrl [NUM_CTRL];
   logic [DATA_WIDTH-1:0] r_txd;
   logic [DATA_WIDTH-1:0] w_txd_nx;
   logic                  r_wr_strobe;
   logic [5:0]            r_wr_addr;
   logic                  r_err;

   // State, address and auto-increment flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_ainc  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_addr  <= w_addr_nx;
         r_ainc  <= w_ainc_nx;
      end
   end

   // Next state, next address, write enable and error detection
   always_comb begin
      w_state_nx = r_state;
      w_addr_nx  = r_addr;
      w_ainc_nx  = r_ainc;
      w_wr_en    = 1'b0;
      w_err_set  = 1'b0;
      if (cmd_done) begin
         // a command always wins; a coincident data word is dropped as an error
         w_addr_nx  = dcmd[5:0];
         w_ainc_nx  = dcmd[6];
         w_state_nx = dcmd[7] ? WR_ARMED : RD_ARMED;
         w_err_set  = data_done;
      end else if (data_done) begin
         case (r_state)
            IDLE:     w_err_set = 1'b1;
            WR_ARMED: begin
               if (r_addr < CTRL_N) w_wr_en   = 1'b1;
               else                 w_err_set = 1'b1;
            end
            RD_ARMED: begin
               if (r_addr > LAST) w_err_set = 1'b1;
            end
            default: w_err_set = 1'b0;
         endcase
         // dropped writes still advance the address
         if ((r_state != IDLE) && r_ainc)
            w_addr_nx = (r_addr == LAST) ? '0 : r_addr + 6'd1;
      end
   end

   // Read mux on the next address so txd_data is ready one cycle after the
   // command or data word; status inputs are re-sampled every cycle.
   always_comb begin
      w_txd_nx = '0;
      if (w_state_nx == RD_ARMED) begin
         for (int unsigned i = 0; i < NUM_CTRL; i++)
            if (w_addr_nx == 6'(i)) w_txd_nx = r_ctrl[i];
         for (int unsigned j = 0; j < NUM_STAT; j++)
            if (w_addr_nx == 6'(NUM_CTRL + j))
               w_txd_nx = stat_flat[j*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Control registers, write strobe, txd and error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_CTRL; i++) r_ctrl[i] <= '0;
         r_txd       <= '0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_err       <= 1'b0;
      end else begin
         r_txd       <= w_txd_nx;
         r_wr_strobe <= w_wr_en;
         if (w_wr_en) begin
            r_wr_addr <= r_addr;
            for (int unsigned i = 0; i < NUM_CTRL; i++)
               if (r_addr == 6'(i)) r_ctrl[i] <= rxd_data;
         end
         if (w_err_set)    r_err <= 1'b1;
         else if (err_clr) r_err <= 1'b0;
      end
   end

   always_comb begin
      ctrl_flat = '0;
      for (int unsigned i = 0; i < NUM_CTRL; i++)
         ctrl_flat[i*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[i];
   end

   assign txd_data  = r_txd;
   assign wr_strobe = r_wr_strobe;
   assign wr_addr   = r_wr_addr;
   assign err       = r_err;

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;

   localparam int DW = 16;
   localparam int NC = 8;
   localparam int NS = 4;
   localparam int LAST = NC + NS - 1;
   localparam int MD_IDLE = 0;
   localparam int MD_WR   = 1;
   localparam int MD_RD   = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    dcmd = '0;
   logic          cmd_done = 1'b0;
   logic [DW-1:0] rxd_data = '0;
   logic          data_done = 1'b0;
   logic [NS*DW-1:0] stat_flat = '0;
   logic          err_clr = 1'b0;
   logic [DW-1:0] txd_data;
   logic [NC*DW-1:0] ctrl_flat;
   logic          wr_strobe;
   logic [5:0]    wr_addr;
   logic          err;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int            m_mode;
   int            m_addr;
   bit            m_ainc;
   logic [DW-1:0] m_ctrl [NC];
   logic [DW-1:0] m_txd;
   bit            m_strobe;
   int            m_waddr;
   bit            m_err;

   always #5 clk = ~clk;

   spi_reg_bank #(.DATA_WIDTH(DW), .CMD_WIDTH(8), .NUM_CTRL(NC), .NUM_STAT(NS)) dut (
      .clk(clk), .rst(rst), .dcmd(dcmd), .cmd_done(cmd_done), .rxd_data(rxd_data),
      .data_done(data_done), .txd_data(txd_data), .stat_flat(stat_flat),
      .ctrl_flat(ctrl_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .err(err),
      .err_clr(err_clr)
   );

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      bit eset;
      eset = 1'b0;
      if (rst) begin
         m_mode = MD_IDLE; m_addr = 0; m_ainc = 1'b0;
         for (int i = 0; i < NC; i++) m_ctrl[i] = '0;
         m_strobe = 1'b0; m_waddr = 0; m_err = 1'b0; m_txd = '0;
         return;
      end
      m_strobe = 1'b0;
      if (cmd_done) begin
         m_addr = int'(dcmd[5:0]);
         m_ainc = dcmd[6];
         m_mode = dcmd[7] ? MD_WR : MD_RD;
         if (data_done) eset = 1'b1;
      end else if (data_done) begin
         if (m_mode == MD_IDLE) eset = 1'b1;
         else begin
            if (m_mode == MD_WR) begin
               if (m_addr < NC) begin
                  m_ctrl[m_addr] = rxd_data; m_strobe = 1'b1; m_waddr = m_addr;
               end else eset = 1'b1;
            end else if (m_addr > LAST) eset = 1'b1;
            if (m_ainc) m_addr = (m_addr == LAST) ? 0 : (m_addr + 1) % 64;
         end
      end
      if (eset) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (m_mode == MD_RD && m_addr < NC) m_txd = m_ctrl[m_addr];
      else if (m_mode == MD_RD && m_addr <= LAST) m_txd = stat_flat[(m_addr-NC)*DW +: DW];
      else m_txd = '0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; cmd_done = 1'b0; data_done = 1'b0; err_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_done = 1'b1; dcmd = 8'h85; tick(); tick();
      idle_inputs();
      n_cmp++; if (txd_data !== 16'h0000) begin n_bad++; $display("FAIL reset_txd got=%h exp=0000", txd_data); end
      n_cmp++; if (ctrl_flat !== '0) begin n_bad++; $display("FAIL reset_ctrl got=%h exp=0", ctrl_flat); end
      n_cmp++; if (wr_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got=%b exp=0", wr_strobe); end
      n_cmp++; if (wr_addr !== 6'd0) begin n_bad++; $display("FAIL reset_waddr got=%0d exp=0", wr_addr); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
   endtask

   task automatic test_write();
      dcmd = 8'h83; cmd_done = 1'b1; tick(); cmd_done = 1'b0;
      rxd_data = 16'hBEEF; data_done = 1'b1; tick(); data_done = 1'b0;
      n_cmp++; if (ctrl_flat[3*DW +: DW] !== 16'hBEEF) begin n_bad++; $display("FAIL write_reg3 got=%h exp=beef", ctrl_flat[3*DW +: DW]); end
      n_cmp++; if (wr_strobe !== 1'b1) begin n_bad++; $display("FAIL write_strobe got=%b exp=1", wr_strobe); end
      n_cmp++; if (wr_addr !== 6'd3) begin n_bad++; $display("FAIL write_waddr got=%0d exp=3", wr_addr); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL write_err got=%b exp=0", err); end
      tick();
      n_cmp++; if (wr_strobe !== 1'b0) begin n_bad++; $display("FAIL write_strobe_end got=%b exp=0", wr_strobe); end
   endtask

   task automatic test_read();
      dcmd = 8'h03; cmd_done = 1'b1; tick(); cmd_done = 1'b0;
      n_cmp++; if (txd_data !== 16'hBEEF) begin n_bad++; $display("FAIL read_ctrl3 got=%h exp=beef", txd_data); end
      stat_flat[1*DW +: DW] = 16'h1234;
      dcmd = 8'h09; cmd_done = 1'b1; tick(); cmd_done = 1'b0;
      n_cmp++; if (txd_data !== 16'h1234) begin n_bad++; $display("FAIL read_stat9 got=%h exp=1234", txd_data); end
      stat_flat[1*DW +: DW] = 16'h4321; tick();
      n_cmp++; if (txd_data !== 16'h4321) begin n_bad++; $display("FAIL read_stat_track got=%h exp=4321", txd_data); end
   endtask

   task automatic test_ainc_write();
      dcmd = 8'hC6; cmd_done = 1'b1; tick(); cmd_done = 1'b0;
      data_done = 1'b1;
      for (int w = 1; w <= 7; w++) begin
         rxd_data = 16'(w); tick();
         if (w == 3) begin
            n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ainc_wr_err got=%b exp=1", err); end
            n_cmp++; if (wr_strobe !== 1'b0) begin n_bad++; $display("FAIL ainc_wr_drop got=%b exp=0", wr_strobe); end
         end
      end
      data_done = 1'b0;
      n_cmp++; if (ctrl_flat[6*DW +: DW] !== 16'd1) begin n_bad++; $display("FAIL ainc_wr_reg6 got=%h exp=0001", ctrl_flat[6*DW +: DW]); end
      n_cmp++; if (ctrl_flat[7*DW +: DW] !== 16'd2) begin n_bad++; $display("FAIL ainc_wr_reg7 got=%h exp=0002", ctrl_flat[7*DW +: DW]); end
      n_cmp++; if (ctrl_flat[0*DW +: DW] !== 16'd7) begin n_bad++; $display("FAIL ainc_wr_wrap got=%h exp=0007", ctrl_flat[0*DW +: DW]); end
      n_cmp++; if (wr_addr !== 6'd0) begin n_bad++; $display("FAIL ainc_wr_waddr got=%0d exp=0", wr_addr); end
   endtask

   task automatic test_ainc_read();
      stat_flat[3*DW +: DW] = 16'hA5A5;
      dcmd = 8'h4B; cmd_done = 1'b1; tick(); cmd_done = 1'b0;
      n_cmp++; if (txd_data !== 16'hA5A5) begin n_bad++; $display("FAIL ainc_rd_stat11 got=%h exp=a5a5", txd_data); end
      data_done = 1'b1; tick(); data_done = 1'b0;
      n_cmp++; if (txd_data !== 16'h0007) begin n_bad++; $display("FAIL ainc_rd_wrap got=%h exp=0007", txd_data); end
   endtask

   task automatic test_errors();
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear got=%b exp=0", err); end
      dcmd = 8'h3F; cmd_done = 1'b1; tick(); cmd_done = 1'b0;
      data_done = 1'b1; tick(); data_done = 1'b0;
      n_cmp++; if (txd_data !== 16'h0000) begin n_bad++; $display("FAIL err_inv_txd got=%h exp=0000", txd_data); end
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_inv_rd got=%b exp=1", err); end
      err_clr = 1'b1; data_done = 1'b1; tick(); data_done = 1'b0;
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_clr_prio got=%b exp=1", err); end
      tick(); err_clr = 1'b0;
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clr2 got=%b exp=0", err); end
      rst = 1'b1; tick(); rst = 1'b0;
      data_done = 1'b1; tick(); data_done = 1'b0;
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_idle got=%b exp=1", err); end
   endtask

   task automatic test_simultaneous();
      rst = 1'b1; tick(); rst = 1'b0;
      dcmd = 8'h81; cmd_done = 1'b1; rxd_data = 16'h5555; data_done = 1'b1; tick();
      cmd_done = 1'b0; data_done = 1'b0;
      n_cmp++; if (ctrl_flat[1*DW +: DW] !== 16'h0000) begin n_bad++; $display("FAIL simul_reg1 got=%h exp=0000", ctrl_flat[1*DW +: DW]); end
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL simul_err got=%b exp=1", err); end
      n_cmp++; if (wr_strobe !== 1'b0) begin n_bad++; $display("FAIL simul_strobe got=%b exp=0", wr_strobe); end
      rxd_data = 16'h1111; data_done = 1'b1; tick(); data_done = 1'b0;
      n_cmp++; if (ctrl_flat[1*DW +: DW] !== 16'h1111) begin n_bad++; $display("FAIL simul_armed got=%h exp=1111", ctrl_flat[1*DW +: DW]); end
      n_cmp++; if (wr_addr !== 6'd1) begin n_bad++; $display("FAIL simul_waddr got=%0d exp=1", wr_addr); end
      stat_flat[0*DW +: DW] = 16'h7777;
      dcmd = 8'h08; cmd_done = 1'b1; tick(); cmd_done = 1'b0;
      rst = 1'b1; data_done = 1'b1; tick(); rst = 1'b0; data_done = 1'b0;
      n_cmp++; if ({txd_data, wr_strobe, wr_addr, err} !== '0) begin n_bad++; $display("FAIL midrst_outs got=%h/%b/%0d/%b exp=0", txd_data, wr_strobe, wr_addr, err); end
      n_cmp++; if (ctrl_flat !== '0) begin n_bad++; $display("FAIL midrst_ctrl got=%h exp=0", ctrl_flat); end
   endtask

   task automatic test_random();
      logic [NC*DW-1:0] exp_flat;
      for (int c = 0; c < 600; c++) begin
         rst       = ($urandom_range(0, 99) < 2);
         cmd_done  = ($urandom_range(0, 99) < 20);
         data_done = ($urandom_range(0, 99) < 35);
         err_clr   = ($urandom_range(0, 99) < 10);
         dcmd      = {2'($urandom), ($urandom_range(0, 19) == 0) ? 6'($urandom) : 6'($urandom_range(0, 13))};
         rxd_data  = 16'($urandom);
         if ($urandom_range(0, 3) == 0) stat_flat = {$urandom, $urandom};
         tick();
         for (int i = 0; i < NC; i++) exp_flat[i*DW +: DW] = m_ctrl[i];
         n_cmp++; if (txd_data !== m_txd) begin n_bad++; $display("FAIL rnd_txd c=%0d got=%h exp=%h", c, txd_data, m_txd); end
         n_cmp++; if (ctrl_flat !== exp_flat) begin n_bad++; $display("FAIL rnd_ctrl c=%0d got=%h exp=%h", c, ctrl_flat, exp_flat); end
         n_cmp++; if (wr_strobe !== m_strobe) begin n_bad++; $display("FAIL rnd_strobe c=%0d got=%b exp=%b", c, wr_strobe, m_strobe); end
         n_cmp++; if (wr_addr !== 6'(m_waddr)) begin n_bad++; $display("FAIL rnd_waddr c=%0d got=%0d exp=%0d", c, wr_addr, m_waddr); end
         n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err, m_err); end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_ainc_write();
      test_ainc_read();
      test_errors();
      test_simultaneous();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
